// File: rtl/softmax_norm.sv
// Softmax normalisation stage: buffers one row of exp values, takes the
// reciprocal of their sum with a serial divider, then streams scaled probabilities.
module softmax_norm #(
  parameter int ROW_LEN = 8,
  parameter int CREDITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       credit_ret,
  output logic       credit_err
);
  localparam int IW = $clog2(ROW_LEN) + 1;
  localparam int SW = 8 + $clog2(ROW_LEN);
  localparam int CW = 4;

  typedef enum logic [1:0] {COLLECT, DIVIDE, EMIT} state_t;

  state_t        state, state_nx;
  logic [7:0]    buffer [ROW_LEN];
  logic [IW-1:0] idx, len, ek;
  logic [SW-1:0] sum, rem;
  logic [15:0]   quo, r;
  logic [4:0]    dcnt;
  logic [CW-1:0] credits;

  logic          accept, row_end, div_done, emit_last, ge;
  logic [SW:0]   rem_sh;
  logic [16:0]   quo_nx;
  logic [23:0]   prod;
  logic [15:0]   scaled;

  assign accept    = in_valid & in_ready;
  assign row_end   = accept & (in_last | (idx == IW'(ROW_LEN - 1)));
  assign div_done  = (state == DIVIDE) && (dcnt == 5'd16);
  assign emit_last = out_valid && (ek == len - 1'b1);

  // Restoring division of 2^16 by sum: the dividend has a single 1 in its MSB.
  assign rem_sh = {rem, dcnt == 5'd0};
  assign ge     = rem_sh >= {1'b0, sum};
  assign quo_nx = {quo, ge};

  assign prod   = {16'd0, buffer[ek[IW-2:0]]} * {8'd0, r};
  assign scaled = 16'(prod >> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (row_end)   state_nx = DIVIDE;
      DIVIDE:  if (div_done)  state_nx = EMIT;
      EMIT:    if (emit_last) state_nx = COLLECT;
      default:                state_nx = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == EMIT) && (credits != '0);
    out_last  = emit_last;
    out_data  = '0;
    if (out_valid) out_data = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk) begin
    if (accept) buffer[idx[IW-2:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      len  <= '0;
      ek   <= '0;
      sum  <= '0;
      rem  <= '0;
      quo  <= '0;
      r    <= '0;
      dcnt <= '0;
    end else begin
      unique case (state)
        COLLECT: if (accept) begin
          idx <= idx + 1'b1;
          sum <= sum + SW'(in_data);
          if (row_end) begin
            len  <= idx + 1'b1;
            dcnt <= '0;
            rem  <= '0;
            quo  <= '0;
          end
        end
        DIVIDE: begin
          dcnt <= dcnt + 1'b1;
          rem  <= SW'(ge ? rem_sh - {1'b0, sum} : rem_sh);
          quo  <= quo_nx[15:0];
          if (div_done) begin
            // sum == 1 yields 65536, which saturates to 16 bits
            r  <= (sum == '0) ? 16'd0 : (quo_nx[16] ? 16'hFFFF : quo_nx[15:0]);
            ek <= '0;
          end
        end
        EMIT: if (out_valid) begin
          ek <= ek + 1'b1;
          if (emit_last) begin
            idx <= '0;
            sum <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      unique case ({out_valid, credit_ret})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CW'(CREDITS)) credit_err <= 1'b1;
          else                         credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_norm.sv
// Randomised and directed bench for softmax_norm against a plain-arithmetic model.
module tb_softmax_norm;
  typedef logic [7:0] bq_t[$];

  logic       clk, rst_n;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data, out_data;
  logic       out_valid, out_last, credit_ret, credit_err;
  int         cyc = 0;
  int         passed = 0, total = 0;

  softmax_norm #(.ROW_LEN(8), .CREDITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .credit_ret(credit_ret), .credit_err(credit_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bq_t model(input bq_t d);
    bq_t o;
    int s = 0, r, v;
    foreach (d[i]) s += d[i];
    r = (s == 0) ? 0 : ((65536 / s > 65535) ? 65535 : 65536 / s);
    foreach (d[i]) begin
      v = (d[i] * r) / 256;
      o.push_back(8'((v > 255) ? 255 : v));
    end
    return o;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; in_last = 0; in_data = 0; credit_ret = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Presents each element until accepted; returns at the negedge after the final accept.
  task automatic drive_row(input bq_t d, input bit mark_last, output int acc_cyc, output bit to);
    to = 0; acc_cyc = -1;
    for (int i = 0; i < d.size(); i++) begin
      int w = 0;
      in_valid = 1; in_data = d[i]; in_last = mark_last && (i == d.size() - 1);
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (!in_ready) to = 1;
      acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 0; in_last = 0; in_data = 0;
  endtask

  task automatic collect(input int maxc, input bit auto_cr, output bq_t o, output bq_t l,
                         output int first_cyc, output bit to, output int rdy_hi, output int zv);
    bit done = 0;
    o = {}; l = {}; first_cyc = -1; to = 1; rdy_hi = 0; zv = 0;
    for (int c = 0; c < maxc; c++) begin
      credit_ret = auto_cr && out_valid;
      if (in_ready) rdy_hi++;
      if (!out_valid && (out_data !== 8'd0 || out_last !== 1'b0)) zv++;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        o.push_back(out_data);
        l.push_back({7'd0, out_last});
        if (out_last) begin done = 1; to = 0; end
      end
      @(negedge clk);
      if (done) break;
    end
    credit_ret = 0;
  endtask

  task automatic pulse_credit();
    credit_ret = 1;
    @(negedge clk);
    credit_ret = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_last = 0; in_data = 0; credit_ret = 0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 8'd0) $display("FAIL reset_out_data got=%0d exp=0", out_data); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else passed++;
    total++; if (credit_err !== 1'b0) $display("FAIL reset_credit_err got=%b exp=0", credit_err); else passed++;
    rst_n = 1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_directed();
    bq_t rows[4], exps[4], o, l;
    int acc, first, rh, zv;
    bit to1, to2;
    rows[0] = '{8'd64, 8'd64, 8'd64, 8'd64}; exps[0] = '{8'd64, 8'd64, 8'd64, 8'd64};
    rows[1] = '{8'd128, 8'd64, 8'd64};       exps[1] = '{8'd128, 8'd64, 8'd64};
    rows[2] = '{8'd100};                     exps[2] = '{8'd255};
    rows[3] = '{8'd0, 8'd0};                 exps[3] = '{8'd0, 8'd0};
    for (int r = 0; r < 4; r++) begin
      drive_row(rows[r], 1, acc, to1);
      collect(60, 1, o, l, first, to2, rh, zv);
      total++; if (to1 || to2) $display("FAIL dir%0d_timeout in=%b out=%b", r, to1, to2); else passed++;
      total++; if (o.size() != exps[r].size()) $display("FAIL dir%0d_count got=%0d exp=%0d", r, o.size(), exps[r].size()); else passed++;
      total++; if (first - acc != 18) $display("FAIL dir%0d_latency got=%0d exp=18", r, first - acc); else passed++;
      for (int k = 0; k < o.size() && k < exps[r].size(); k++) begin
        total++;
        if (o[k] !== exps[r][k] || l[k] !== 8'(k == exps[r].size() - 1))
          $display("FAIL dir%0d_elem%0d data got=%0d exp=%0d last got=%0d", r, k, o[k], exps[r][k], l[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    bq_t d, e, o, l;
    int acc, first, rh, zv, n;
    bit to1, to2;
    for (int r = 0; r < 8; r++) begin
      d = {};
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        d.push_back(8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255)));
      e = model(d);
      drive_row(d, 1, acc, to1);
      collect(60, 1, o, l, first, to2, rh, zv);
      total++;
      if (to1 || to2 || o != e || first - acc != 18 || l[$] !== 8'd1 || zv != 0)
        $display("FAIL rand%0d len=%0d outs=%0d exp=%0d latency=%0d zv=%0d", r, n, o.size(), e.size(), first - acc, zv);
      else passed++;
    end
  endtask

  task automatic test_full_row();
    bq_t d, e, o, l;
    int acc, first, rh, zv;
    bit to1, to2;
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom_range(1, 255)));
    e = model(d);
    drive_row(d, 0, acc, to1);
    total++; if (in_ready !== 1'b0) $display("FAIL full_ready_after_8 got=%b exp=0", in_ready); else passed++;
    collect(60, 1, o, l, first, to2, rh, zv);
    total++; if (to1 || to2) $display("FAIL full_timeout in=%b out=%b", to1, to2); else passed++;
    total++; if (rh != 0) $display("FAIL full_ready_during_row got=%0d high cycles exp=0", rh); else passed++;
    total++; if (o != e) $display("FAIL full_data got_n=%0d exp_n=%0d", o.size(), e.size()); else passed++;
    total++; if (l.size() != 8 || l[7] !== 8'd1 || l[6] !== 8'd0) $display("FAIL full_last got_n=%0d", l.size()); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL full_ready_after_emit got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_credits();
    bq_t d, e, o, l, all;
    int acc, first, rh, zv;
    bit to1, to2;
    apply_reset();
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom_range(1, 255)));
    e = model(d);
    drive_row(d, 1, acc, to1);
    collect(40, 0, o, l, first, to2, rh, zv);
    all = o;
    total++; if (o.size() != 2 || to2 !== 1'b1) $display("FAIL credit_stall got=%0d outs exp=2", o.size()); else passed++;
    total++; if (zv != 0) $display("FAIL credit_idle_zero got=%0d violations exp=0", zv); else passed++;
    pulse_credit();
    collect(10, 0, o, l, first, to2, rh, zv);
    all = {all, o};
    total++; if (o.size() != 1) $display("FAIL credit_one_more got=%0d outs exp=1", o.size()); else passed++;
    pulse_credit();
    collect(10, 0, o, l, first, to2, rh, zv);
    all = {all, o};
    total++; if (o.size() != 1 || to2) $display("FAIL credit_final got=%0d outs timeout=%b exp=1", o.size(), to2); else passed++;
    total++; if (all != e) $display("FAIL credit_data got_n=%0d exp_n=%0d", all.size(), e.size()); else passed++;
    pulse_credit();
    pulse_credit();
    total++; if (credit_err !== 1'b0) $display("FAIL credit_err_early got=%b exp=0", credit_err); else passed++;
    pulse_credit();
    total++; if (credit_err !== 1'b1) $display("FAIL credit_err_set got=%b exp=1", credit_err); else passed++;
    repeat (5) @(negedge clk);
    total++; if (credit_err !== 1'b1) $display("FAIL credit_err_sticky got=%b exp=1", credit_err); else passed++;
  endtask

  task automatic test_reset_mid();
    bq_t d, e, o, l;
    int acc, first, rh, zv;
    bit to1, to2;
    apply_reset();
    total++; if (credit_err !== 1'b0) $display("FAIL mid_err_cleared got=%b exp=0", credit_err); else passed++;
    d = '{8'd200, 8'd17};
    drive_row(d, 0, acc, to1);
    rst_n = 0; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_async_ready got=%b exp=1", in_ready); else passed++;
    @(negedge clk); rst_n = 1; @(negedge clk);
    collect(30, 1, o, l, first, to2, rh, zv);
    total++; if (o.size() != 0) $display("FAIL mid_row_discard got=%0d outs exp=0", o.size()); else passed++;
    d = '{8'd30, 8'd90, 8'd5};
    e = model(d);
    drive_row(d, 1, acc, to1);
    collect(60, 1, o, l, first, to2, rh, zv);
    total++; if (o != e || to2) $display("FAIL mid_fresh_row got_n=%0d exp_n=%0d", o.size(), e.size()); else passed++;
    d = '{8'd40, 8'd41, 8'd42, 8'd43};
    drive_row(d, 1, acc, to1);
    collect(25, 0, o, l, first, to2, rh, zv);
    rst_n = 0; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_emit_async ready=%b valid=%b", in_ready, out_valid); else passed++;
    @(negedge clk); rst_n = 1; @(negedge clk);
    collect(30, 1, o, l, first, to2, rh, zv);
    total++; if (o.size() != 0) $display("FAIL mid_emit_discard got=%0d outs exp=0", o.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_full_row();
    test_credits();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter ROW_LEN, default 8, meaning maximum exp values per softmax row (power of two, 2..64).
REQ-002 SHALL have parameter CREDITS, default 2, meaning initial and maximum downstream credit count (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_data  input  8  exp-stage result, unsigned Q2.6.
REQ-007 SHALL have port in_last  input  1  in_data is the final element of the row.
REQ-008 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data is valid; one pulse consumes one credit.
REQ-010 SHALL have port out_data  output  8  normalized probability, unsigned Q0.8.
REQ-011 SHALL have port out_last  output  1  out_data is the final element of the row.
REQ-012 SHALL have port credit_ret  input  1  one-cycle pulse returning one credit from downstream.
REQ-013 SHALL have port credit_err  output  1  sticky flag: a credit was returned while the count was already CREDITS.

Function
REQ-014 SHALL implement states COLLECT, DIVIDE, EMIT; reset state is COLLECT.
REQ-015 SHALL drive in_ready high only in COLLECT; an input is accepted on in_valid & in_ready.
REQ-016 In COLLECT, each accepted in_data SHALL be stored in buffer[idx], idx SHALL increment, and sum (8+log2(ROW_LEN) bits, no overflow possible) SHALL accumulate it.
REQ-017 The row SHALL end when an accepted element carries in_last or when idx reaches ROW_LEN; the stored length L = idx and the state SHALL go to DIVIDE.
REQ-018 DIVIDE SHALL compute R = min(65535, floor(65536/sum)) with a restoring divider, occupying exactly 17 cycles; for sum == 0 SHALL set R = 0 and still take 17 cycles.
REQ-019 EMIT SHALL output elements in arrival order; element k: out_data = min(255, (buffer[k]*R) >> 8), truncating.
REQ-020 In EMIT, out_valid SHALL assert for exactly one cycle per element, only when credit count > 0; otherwise it SHALL stall with out_valid low.
REQ-021 out_last SHALL be high together with out_valid for element L-1 only; the cycle after it the state SHALL return to COLLECT with idx = 0, sum = 0.
REQ-022 Latency: with credits available, first out_valid SHALL occur 18 cycles after the cycle the final element is accepted; then one element per cycle.
REQ-023 Credit count SHALL decrement on out_valid, increment on credit_ret, and stay unchanged when both occur in the same cycle.
REQ-024 credit_ret at count == CREDITS without a simultaneous out_valid SHALL leave the count at CREDITS and set credit_err until reset.
REQ-025 out_data and out_last SHALL be 0 whenever out_valid is low.

Reset
REQ-026 rst_n low SHALL immediately clear state to COLLECT, idx, sum, R to 0, credit count to CREDITS, out_valid, out_data, out_last, credit_err to 0, and set in_ready to 1 once out of reset.
REQ-027 Reset asserted mid-row or mid-EMIT SHALL discard the partial row; no output SHALL follow for it.

Verification
REQ-028 Four inputs of 64, last on 4th -> sum 256, R 256; outputs 64,64,64,64, out_last on 4th, first out_valid 18 cycles after last accept.
REQ-029 Row 128,64,64 (last on 3rd) -> outputs 128,64,64.
REQ-030 Single input 100 with in_last -> R 655; output 255 (clamped), out_last high.
REQ-031 Row 0,0 -> sum 0; outputs 0,0 after 17-cycle DIVIDE.
REQ-032 CREDITS=2, 4-element row, no credit_ret -> exactly 2 outputs then stall; one credit_ret pulse -> exactly 1 more output; a credit_ret at full count -> credit_err high.
REQ-033 Eight inputs with no in_last (ROW_LEN=8) -> row ends after 8th accept, in_ready low until the 8th output has been emitted.
